// File: rtl/config_regs_banked.sv
// Banked shadow/active configuration registers: firmware op-codes edit shadow copies, and a commit publishes them.
// Latency: every op takes effect one cycle after it is sampled. There is no backpressure; an op is accepted on every cycle.
module config_regs_banked #(
  parameter int NUM_ARRAYS = 2,
  parameter int DEPTH      = 256,
  parameter int WIDTH      = 16
) (
  input  logic                                         fw_clk_100,
  input  logic                                         fw_rst_n,
  input  logic                                         op_code_w_reset,
  input  logic                                         op_code_w_cfg_static_0,
  input  logic [NUM_ARRAYS-1:0]                        op_code_w_cfg_array,
  input  logic [NUM_ARRAYS-1:0]                        op_code_w_cfg_array_inc,
  input  logic                                         op_code_w_ptr_set,
  input  logic                                         op_code_w_commit,
  input  logic [NUM_ARRAYS-1:0]                        op_code_r_cfg_array,
  input  logic [23:0]                                  sw_write24_0,
  output logic [23:0]                                  config_static_0,
  output logic [NUM_ARRAYS-1:0][DEPTH-1:0][WIDTH-1:0]  config_array,
  output logic [15:0]                                  rd_data,
  output logic                                         rd_valid,
  output logic [7:0]                                   wr_ptr,
  output logic                                         cfg_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NUM_ARRAYS-1:0][DEPTH-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [NUM_ARRAYS-1:0][DEPTH-1:0][WIDTH-1:0] active_q, active_d;
  logic [23:0]      static_q, static_d;
  logic [7:0]       wr_ptr_q, wr_ptr_d;
  logic             cfg_err_q, cfg_err_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic [7:0]       addr;
  logic             addr_ok;
  logic [AW-1:0]    addr_idx;
  logic [AW-1:0]    ptr_idx;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd_word;

  assign addr     = sw_write24_0[23:16];
  assign addr_ok  = int'(addr) < DEPTH;
  assign addr_idx = addr[AW-1:0];
  assign ptr_idx  = wr_ptr_q[AW-1:0];
  assign wdata    = sw_write24_0[WIDTH-1:0];

  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    static_d   = static_q;
    wr_ptr_d   = wr_ptr_q;
    cfg_err_d  = cfg_err_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_word    = '0;

    if (op_code_w_reset) begin
      shadow_d  = '0;
      active_d  = '0;
      static_d  = '0;
      wr_ptr_d  = '0;
      cfg_err_d = 1'b0;
      rd_data_d = '0;
    end else begin
      // Commit reads shadow_q, so a write in the same cycle misses this commit.
      if (op_code_w_commit) active_d = shadow_q;

      if (op_code_w_ptr_set) begin
        if (addr_ok) wr_ptr_d = addr;
        else         cfg_err_d = 1'b1;
      end else if (op_code_w_cfg_static_0) begin
        static_d = sw_write24_0;
      end else if (|op_code_w_cfg_array) begin
        if (!$onehot(op_code_w_cfg_array) || !addr_ok) begin
          cfg_err_d = 1'b1;
        end else begin
          for (int i = 0; i < NUM_ARRAYS; i++)
            if (op_code_w_cfg_array[i]) shadow_d[i][addr_idx] = wdata;
        end
      end else if (|op_code_w_cfg_array_inc) begin
        if (!$onehot(op_code_w_cfg_array_inc)) begin
          cfg_err_d = 1'b1;
        end else begin
          for (int i = 0; i < NUM_ARRAYS; i++)
            if (op_code_w_cfg_array_inc[i]) shadow_d[i][ptr_idx] = wdata;
          wr_ptr_d = (int'(wr_ptr_q) == DEPTH - 1) ? 8'd0 : wr_ptr_q + 8'd1;
        end
      end

      // Readback sees the pre-write shadow, so it returns the old value on a same-cycle write.
      if (|op_code_r_cfg_array) begin
        if (!$onehot(op_code_r_cfg_array) || !addr_ok) begin
          cfg_err_d = 1'b1;
        end else begin
          for (int i = 0; i < NUM_ARRAYS; i++)
            if (op_code_r_cfg_array[i]) rd_word = shadow_q[i][addr_idx];
          rd_data_d  = 16'(rd_word);
          rd_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      shadow_q   <= '0;
      active_q   <= '0;
      static_q   <= '0;
      wr_ptr_q   <= '0;
      cfg_err_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      static_q   <= static_d;
      wr_ptr_q   <= wr_ptr_d;
      cfg_err_q  <= cfg_err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign config_static_0 = static_q;
  assign config_array    = active_q;
  assign rd_data         = rd_data_q;
  assign rd_valid        = rd_valid_q;
  assign wr_ptr          = wr_ptr_q;
  assign cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_config_regs_banked.sv
// Bench for config_regs_banked: a default instance plus a DEPTH=64 instance that shares its stimulus.
// Readback results pass through a scoreboard queue. All other outputs are checked directly after each edge.
module tb_config_regs_banked;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_reset, op_static, op_ptr_set, op_commit;
  logic [1:0]  op_arr, op_inc, op_rd;
  logic [23:0] sw;

  logic [23:0]             stat, stat64;
  logic [1:0][255:0][15:0] cfg_arr;
  logic [1:0][63:0][15:0]  cfg_arr64;
  logic [15:0]             rd_data, rd_data64;
  logic                    rd_valid, rd_valid64;
  logic [7:0]              wr_ptr, wr_ptr64;
  logic                    cfg_err, cfg_err64;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];
  int m_sh[2][256];

  always #5 clk = ~clk;

  config_regs_banked u_dut (
    .fw_clk_100(clk), .fw_rst_n(rst_n),
    .op_code_w_reset(op_reset), .op_code_w_cfg_static_0(op_static),
    .op_code_w_cfg_array(op_arr), .op_code_w_cfg_array_inc(op_inc),
    .op_code_w_ptr_set(op_ptr_set), .op_code_w_commit(op_commit),
    .op_code_r_cfg_array(op_rd), .sw_write24_0(sw),
    .config_static_0(stat), .config_array(cfg_arr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_ptr(wr_ptr), .cfg_err(cfg_err)
  );

  config_regs_banked #(.NUM_ARRAYS(2), .DEPTH(64), .WIDTH(16)) u_dut64 (
    .fw_clk_100(clk), .fw_rst_n(rst_n),
    .op_code_w_reset(op_reset), .op_code_w_cfg_static_0(op_static),
    .op_code_w_cfg_array(op_arr), .op_code_w_cfg_array_inc(op_inc),
    .op_code_w_ptr_set(op_ptr_set), .op_code_w_commit(op_commit),
    .op_code_r_cfg_array(op_rd), .sw_write24_0(sw),
    .config_static_0(stat64), .config_array(cfg_arr64), .rd_data(rd_data64),
    .rd_valid(rd_valid64), .wr_ptr(wr_ptr64), .cfg_err(cfg_err64)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_ops();
    op_reset = 0; op_static = 0; op_ptr_set = 0; op_commit = 0;
    op_arr = '0; op_inc = '0; op_rd = '0; sw = '0;
  endtask

  // Applies whatever ops are currently driven on one edge, then leaves the bench 1ns past that edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    clr_ops();
  endtask

  task automatic rd(input logic [1:0] sel, input logic [7:0] a, input logic [15:0] exp);
    op_rd = sel; sw = {a, 16'h0};
    exp_q.push_back(exp);
    cyc();
  endtask

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) check("rd_unexpected", 32'(rd_valid), 32'd0);
      else check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    logic [7:0]  a;
    logic [15:0] d;
    logic [1:0]  s;
    clr_ops();
    rst_n = 1'b0;
    #12;
    check("rst_static", 32'(stat), 0);
    check("rst_ptr", 32'(wr_ptr), 0);
    check("rst_err", 32'(cfg_err), 0);
    check("rst_rdv", 32'(rd_valid), 0);
    check("rst_arr", 32'(|cfg_arr), 0);
    #10 rst_n = 1'b1;

    // The first op lands on the first edge after release.
    op_arr = 2'b01; sw = 24'h05ABCD; cyc();
    check("pre_commit", 32'(cfg_arr[0][5]), 0);
    op_commit = 1; cyc();
    check("post_commit", 32'(cfg_arr[0][5]), 32'hABCD);
    rd(2'b01, 8'h05, 16'hABCD);

    op_static = 1; sw = 24'hA51234; cyc();
    check("static", 32'(stat), 32'hA51234);

    // Incrementing writes wrap the pointer at DEPTH-1.
    op_ptr_set = 1; sw = 24'hFE0000; cyc();
    check("ptr_set", 32'(wr_ptr), 32'hFE);
    op_inc = 2'b10; sw = 24'h000001; cyc();
    check("ptr_inc1", 32'(wr_ptr), 32'hFF);
    op_inc = 2'b10; sw = 24'h000002; cyc();
    check("ptr_wrap", 32'(wr_ptr), 32'h00);
    op_inc = 2'b10; sw = 24'h000003; cyc();
    op_commit = 1; cyc();
    check("inc_fe", 32'(cfg_arr[1][8'hFE]), 1);
    check("inc_ff", 32'(cfg_arr[1][8'hFF]), 2);
    check("inc_00", 32'(cfg_arr[1][0]), 3);
    check("inc_ptr", 32'(wr_ptr), 1);

    // A commit issued with a write copies the pre-write shadow.
    op_arr = 2'b01; sw = 24'h101111; cyc();
    op_commit = 1; cyc();
    op_arr = 2'b01; sw = 24'h101234; op_commit = 1; cyc();
    check("wc_old", 32'(cfg_arr[0][8'h10]), 32'h1111);
    op_commit = 1; cyc();
    check("wc_new", 32'(cfg_arr[0][8'h10]), 32'h1234);

    // Write-op priority.
    op_ptr_set = 1; op_static = 1; op_arr = 2'b01; op_commit = 1; sw = 24'h204321; cyc();
    check("pri_ptr", 32'(wr_ptr), 32'h20);
    check("pri_static_kept", 32'(stat), 32'hA51234);
    rd(2'b01, 8'h20, 16'h0000);
    op_static = 1; op_arr = 2'b01; sw = 24'h215555; cyc();
    check("pri_static", 32'(stat), 32'h215555);
    rd(2'b01, 8'h21, 16'h0000);
    op_arr = 2'b01; op_inc = 2'b10; sw = 24'h226666; cyc();
    check("pri_inc_dropped", 32'(wr_ptr), 32'h20);
    rd(2'b01, 8'h22, 16'h6666);
    rd(2'b10, 8'h20, 16'h0000);

    // Readback strobe, same-cycle read/write, hold, and a bad select.
    op_arr = 2'b01; sw = 24'h037777; cyc();
    check("err_clean", 32'(cfg_err), 0);
    rd(2'b01, 8'h03, 16'h7777);
    check("rdv_high", 32'(rd_valid), 1);
    cyc();
    check("rdv_one_cycle", 32'(rd_valid), 0);
    op_arr = 2'b01; op_rd = 2'b01; sw = 24'h038888; exp_q.push_back(16'h7777); cyc();
    rd(2'b01, 8'h03, 16'h8888);
    cyc();
    check("rd_hold", 32'(rd_data), 32'h8888);
    op_rd = 2'b11; sw = 24'h030000; cyc();
    check("bad_sel_rdv", 32'(rd_valid), 0);
    check("bad_sel_err", 32'(cfg_err), 1);
    cyc();
    check("rd_hold2", 32'(rd_data), 32'h8888);

    // The reset op wins over everything else in its cycle.
    op_reset = 1; op_commit = 1; op_arr = 2'b01; op_ptr_set = 1; sw = 24'h059999; cyc();
    check("clr_err", 32'(cfg_err), 0);
    check("clr_static", 32'(stat), 0);
    check("clr_ptr", 32'(wr_ptr), 0);
    check("clr_arr05", 32'(cfg_arr[0][5]), 0);
    check("clr_arr1fe", 32'(cfg_arr[1][8'hFE]), 0);
    check("clr_err64", 32'(cfg_err64), 0);

    // DEPTH=64 instance: out-of-range addressing and pointer wrap.
    op_arr = 2'b01; sw = 24'h409999; cyc();
    check("oor_err64", 32'(cfg_err64), 1);
    check("oor_err256", 32'(cfg_err), 0);
    op_commit = 1; cyc();
    check("oor_nochange64", 32'(|cfg_arr64), 0);
    op_reset = 1; cyc();
    check("oor_clr64", 32'(cfg_err64), 0);
    op_ptr_set = 1; sw = 24'h3F0000; cyc();
    check("ptr64_set", 32'(wr_ptr64), 32'h3F);
    op_inc = 2'b01; sw = 24'h000001; cyc();
    op_inc = 2'b01; sw = 24'h000002; cyc();
    check("ptr64_wrap", 32'(wr_ptr64), 32'h01);
    op_ptr_set = 1; sw = 24'h400000; cyc();
    check("ptr64_oor_kept", 32'(wr_ptr64), 32'h01);
    check("ptr64_oor_err", 32'(cfg_err64), 1);
    op_reset = 1; cyc();

    // Random addressed writes against a shadow model.
    foreach (m_sh[i, j]) m_sh[i][j] = 0;
    for (int k = 0; k < 20; k++) begin
      a = 8'($urandom_range(255));
      d = 16'($urandom_range(16'hFFFF));
      s = 2'b01 << $urandom_range(1);
      op_arr = s; sw = {a, d}; cyc();
      m_sh[s[1]][a] = int'(d);
      rd(s, a, d);
      a = 8'($urandom_range(255));
      rd(2'b10, a, 16'(m_sh[1][a]));
    end

    // Asynchronous reset in the middle of an incrementing burst.
    op_static = 1; sw = 24'hC0FFEE; cyc();
    op_arr = 2'b01; sw = 24'h80BEEF; cyc();
    op_commit = 1; cyc();
    op_ptr_set = 1; sw = 24'h100000; cyc();
    op_inc = 2'b01; sw = 24'h000011; cyc();
    op_inc = 2'b01; sw = 24'h000022; cyc();
    check("burst_ptr", 32'(wr_ptr), 32'h12);
    op_inc = 2'b01; sw = 24'h000033;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_static", 32'(stat), 0);
    check("arst_ptr", 32'(wr_ptr), 0);
    check("arst_arr", 32'(|cfg_arr), 0);
    check("arst_rdd", 32'(rd_data), 0);
    check("arst_rdv", 32'(rd_valid), 0);
    clr_ops();
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc();
    check("arst_ptr_after", 32'(wr_ptr), 0);
    op_commit = 1; cyc();
    check("arst_no_partial", 32'(|cfg_arr), 0);
    rd(2'b01, 8'h10, 16'h0000);

    cyc();
    cyc();
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/config_regs_banked.md
CONFIG_REGS_BANKED -- requirements
Module: config_regs_banked

Interface
REQ-001 Parameter NUM_ARRAYS, default 2: number of configuration arrays, range 1..8.
REQ-002 Parameter DEPTH, default 256: entries per array, range 2..256.
REQ-003 Parameter WIDTH, default 16: bits per entry, range 1..16.
REQ-004 fw_clk_100  input  1: FW clock, 100 MHz, mapped to S_AXI_ACLK; the only clock.
REQ-005 fw_rst_n  input  1: FW reset, asynchronous, active-low, mapped to S_AXI_ARESETN.
REQ-006 op_code_w_reset  input  1: synchronous clear of all state.
REQ-007 op_code_w_cfg_static_0  input  1: write the static register.
REQ-008 op_code_w_cfg_array  input  NUM_ARRAYS: one-hot array select, addressed write.
REQ-009 op_code_w_cfg_array_inc  input  NUM_ARRAYS: one-hot array select, write at the pointer, then increment the pointer.
REQ-010 op_code_w_ptr_set  input  1: load the pointer.
REQ-011 op_code_w_commit  input  1: copy all shadow arrays to the active arrays.
REQ-012 op_code_r_cfg_array  input  NUM_ARRAYS: one-hot array select, shadow readback request.
REQ-013 sw_write24_0  input  24: [23:16] address or pointer value, [15:0] data; the full word is static data.
REQ-014 config_static_0  output  24: static configuration.
REQ-015 config_array  output  NUM_ARRAYS x DEPTH x WIDTH: active (committed) arrays.
REQ-016 rd_data  output  16: readback data, zero-extended from WIDTH.
REQ-017 rd_valid  output  1: one-cycle readback strobe.
REQ-018 wr_ptr  output  8: current auto-increment pointer.
REQ-019 cfg_err  output  1: sticky error flag.

Function
REQ-020 Every op-code input shall be sampled on the rising edge of fw_clk_100, and every effect shall be visible one cycle later.
REQ-021 The block shall hold one shadow array and one active array per index; all writes shall target the shadow array only.
REQ-022 An addressed write shall store shadow[sel][addr] <= sw_write24_0[WIDTH-1:0], where addr = sw_write24_0[23:16].
REQ-023 An incrementing write shall store shadow[sel][wr_ptr] <= sw_write24_0[WIDTH-1:0] and then set wr_ptr to wr_ptr+1, wrapping from DEPTH-1 to 0.
REQ-024 op_code_w_ptr_set shall load wr_ptr <= sw_write24_0[23:16] when that value is below DEPTH; otherwise it shall leave wr_ptr unchanged and set cfg_err.
REQ-025 An addressed write or readback with addr >= DEPTH shall be ignored and shall set cfg_err.
REQ-026 A select vector that is not one-hot and not zero shall cause no write and no readback, and shall set cfg_err.
REQ-027 A commit shall copy every shadow array to its active array in a single cycle.
REQ-028 When a commit and a write arrive in the same cycle, the commit shall copy the pre-write shadow and the write shall land in the shadow only.
REQ-029 A readback shall drive rd_data with shadow[sel][addr] and pulse rd_valid high for one cycle, both on the following cycle.
REQ-030 A readback in the same cycle as a write to the same entry shall return the old value.
REQ-031 rd_data shall hold its last value while rd_valid is low.
REQ-032 When more than one write op-code is active in a cycle, priority shall be: reset > ptr_set > cfg_static_0 > cfg_array > cfg_array_inc; lower-priority writes are dropped, and commit and readback proceed independently.
REQ-033 op_code_w_reset shall clear all shadow and active arrays, config_static_0, wr_ptr and cfg_err, and suppress every other op in that cycle.
REQ-034 cfg_err shall remain set until op_code_w_reset or fw_rst_n.
REQ-035 Outputs shall be registered, with no combinational path from any input to any output.

Reset
REQ-036 While fw_rst_n is low, all outputs and internal state shall be 0, regardless of the clock.
REQ-037 An assertion of fw_rst_n mid-burst shall abort the burst, leave wr_ptr at 0, and leave no partial commit.
REQ-038 The first op-code shall be accepted on the first rising edge after fw_rst_n deasserts.

Verification
REQ-039 Write array0 addr 0x05 = 0xABCD, then commit: config_array[0][5] is 0xABCD one cycle after the commit, and 0 before it.
REQ-040 ptr_set 0xFE, then three inc writes 1, 2, 3 to array1 (DEPTH=256), then commit: entries 0xFE=1, 0xFF=2, 0x00=3 and wr_ptr = 0x01.
REQ-041 Write 0x1234 and commit in the same cycle, then a second commit: active holds the old value after the first commit and 0x1234 after the second.
REQ-042 With DEPTH=64, write addr 0x40: no array change and cfg_err = 1; op_code_w_reset then clears cfg_err to 0.
REQ-043 Write addr 3 = 0x7777, then readback addr 3 on array0: rd_valid high for exactly one cycle with rd_data = 0x7777; select 2'b11 gives no rd_valid and cfg_err = 1.
REQ-044 Pulse fw_rst_n low mid-cycle during an inc burst: all outputs are 0 immediately and wr_ptr = 0 after release.
